char_buf_ctl: RTL and testbench

Double-buffered character-memory controller for the text overlay. It holds two 16x16 banks of 8-bit character codes. The display reads the front bank, looking it up by the character cell index that draw_rect_char already produces, and `char_code` feeds the font ROM address formation. A writer fills the back bank, and a frame-synchronous commit swaps the banks at the start of vertical blanking so text changes never tear mid-frame.

---
 rtl/char_buf_ctl.sv | 169 ++++++++++++++++
 tb/tb_char_buf_ctl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_buf_ctl.sv
`default_nettype none
// ============================================================================
// Module      : char_buf_ctl
// Description : Double-buffered 16x16 character memory with a vblank-aligned
//               bank swap and a back-bank refresh from the new front bank.
// Revision    : 1.0 - initial release
// ============================================================================
module char_buf_ctl #(
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk_in,
    input  logic [7:0] char_xy,
    output logic [7:0] char_code,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_char,
    input  logic       clear,
    input  logic       commit,
    output logic       busy,
    output logic       commit_done
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_CLEAR   = 3'd2,
        S_WAIT_VS = 3'd3,
        S_COPY    = 3'd4
    } state_t;

    state_t     r_state;
    logic [7:0] r_idx;
    logic       r_front_sel;
    logic       r_vblnk_prev;
    logic       r_wr_ready;
    logic       r_busy;
    logic       r_commit_done;
    logic [7:0] r_char_code;

    logic [7:0] r_bank0 [256];
    logic [7:0] r_bank1 [256];

    logic       w_idx_last;
    logic       w_swap;
    logic [7:0] w_front_at_idx;
    logic       w_we_back;
    logic       w_we_both;
    logic       w_we0;
    logic       w_we1;
    logic [7:0] w_waddr;
    logic [7:0] w_wdata;

    assign w_idx_last     = (r_idx == 8'hFF);
    assign w_swap         = vblnk_in && !r_vblnk_prev;
    assign w_front_at_idx = r_front_sel ? r_bank1[r_idx] : r_bank0[r_idx];

    // Single shared write port per bank; the back bank is the one not selected.
    always_comb begin
        w_we_back = 1'b0;
        w_we_both = 1'b0;
        w_waddr   = r_idx;
        w_wdata   = FILL_CHAR;
        if (!rst) begin
            case (r_state)
                S_INIT: begin
                    w_we_both = 1'b1;
                end
                S_IDLE: begin
                    if (wr_valid) begin
                        w_we_back = 1'b1;
                        w_waddr   = wr_addr;
                        w_wdata   = wr_char;
                    end
                end
                S_CLEAR: begin
                    w_we_back = 1'b1;
                end
                S_COPY: begin
                    w_we_back = 1'b1;
                    w_wdata   = w_front_at_idx;
                end
                default: begin
                    w_we_back = 1'b0;
                end
            endcase
        end
    end

    assign w_we0 = w_we_both || (w_we_back &&  r_front_sel);
    assign w_we1 = w_we_both || (w_we_back && !r_front_sel);

    always_ff @(posedge clk) begin
        if (w_we0) begin
            r_bank0[w_waddr] <= w_wdata;
        end
        if (w_we1) begin
            r_bank1[w_waddr] <= w_wdata;
        end
    end

    // Display read runs in every state; the swap-edge cycle still sees the old bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_char_code <= 8'h00;
        end else begin
            r_char_code <= r_front_sel ? r_bank1[char_xy] : r_bank0[char_xy];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_INIT;
            r_idx         <= 8'd0;
            r_front_sel   <= 1'b0;
            r_vblnk_prev  <= 1'b0;
            r_wr_ready    <= 1'b0;
            r_busy        <= 1'b1;
            r_commit_done <= 1'b0;
        end else begin
            r_vblnk_prev  <= vblnk_in;
            r_commit_done <= 1'b0;
            case (r_state)
                S_INIT, S_CLEAR, S_COPY: begin
                    r_idx <= w_idx_last ? 8'd0 : r_idx + 8'd1;
                    if (w_idx_last) begin
                        r_state       <= S_IDLE;
                        r_wr_ready    <= 1'b1;
                        r_busy        <= 1'b0;
                        r_commit_done <= (r_state == S_COPY);
                    end
                end
                S_IDLE: begin
                    if (commit) begin
                        r_state    <= S_WAIT_VS;
                        r_wr_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end else if (clear) begin
                        r_state    <= S_CLEAR;
                        r_wr_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_WAIT_VS: begin
                    // Only a fresh rising edge counts; a level already high is skipped.
                    if (w_swap) begin
                        r_front_sel <= ~r_front_sel;
                        r_state     <= S_COPY;
                    end
                end
                default: begin
                    r_state    <= S_INIT;
                    r_idx      <= 8'd0;
                    r_wr_ready <= 1'b0;
                    r_busy     <= 1'b1;
                end
            endcase
        end
    end

    assign char_code   = r_char_code;
    assign wr_ready    = r_wr_ready;
    assign busy        = r_busy;
    assign commit_done = r_commit_done;

endmodule
`default_nettype wire

// File: tb/tb_char_buf_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_char_buf_ctl
// Description : Scoreboard bench for char_buf_ctl against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_char_buf_ctl;

    localparam logic [7:0] c_fill = 8'h20;

    logic       clk;
    logic       rst;
    logic       vblnk_in;
    logic [7:0] char_xy;
    logic [7:0] char_code;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [7:0] wr_char;
    logic       clear;
    logic       commit;
    logic       busy;
    logic       commit_done;

    char_buf_ctl #(.FILL_CHAR(c_fill)) dut (
        .clk        (clk),
        .rst        (rst),
        .vblnk_in   (vblnk_in),
        .char_xy    (char_xy),
        .char_code  (char_code),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_char    (wr_char),
        .clear      (clear),
        .commit     (commit),
        .busy       (busy),
        .commit_done(commit_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit         rd_chk;
        logic [7:0] code;
        bit         dir_en;
        logic [7:0] dir_val;
        logic       ready;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Frame-level model: the displayed image and the writer's image.
    // A swap publishes the writer image; the refresh copy leaves it untouched.
    localparam int K_INIT  = 0;
    localparam int K_CLEAR = 1;
    localparam int K_COPY  = 2;
    logic [7:0] m_disp [256];
    logic [7:0] m_edit [256];
    int  m_left    = 0;
    int  m_kind    = K_INIT;
    bit  m_wait    = 0;
    bit  m_disp_ok = 0;
    bit  m_prev_vb = 0;

    int         frame_cnt  = 0;
    bit         focus_en   = 0;
    logic [7:0] focus_addr = 8'h00;
    bit         dir_en     = 0;
    logic [7:0] dir_val    = 8'h00;

    task automatic model_step();
        exp_t e;
        bit   done_nxt;
        done_nxt  = 1'b0;
        e.rd_chk  = rst ? 1'b1 : m_disp_ok;
        e.code    = rst ? 8'h00 : m_disp[char_xy];
        e.dir_en  = dir_en && !rst;
        e.dir_val = dir_val;
        if (rst) begin
            m_left = 256; m_kind = K_INIT; m_wait = 0; m_disp_ok = 0; m_prev_vb = 0;
            for (int i = 0; i < 256; i++) begin
                m_disp[i] = c_fill;
                m_edit[i] = c_fill;
            end
        end else begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_kind == K_COPY) done_nxt = 1'b1;
                    if (m_kind == K_INIT) m_disp_ok = 1'b1;
                end
            end else if (m_wait) begin
                if (vblnk_in && !m_prev_vb) begin
                    m_disp = m_edit;
                    m_wait = 0;
                    m_left = 256;
                    m_kind = K_COPY;
                end
            end else begin
                if (wr_valid) m_edit[wr_addr] = wr_char;
                if (commit) begin
                    m_wait = 1;
                end else if (clear) begin
                    for (int i = 0; i < 256; i++) m_edit[i] = c_fill;
                    m_left = 256;
                    m_kind = K_CLEAR;
                end
            end
            m_prev_vb = vblnk_in;
        end
        e.ready = (m_left == 0) && !m_wait;
        e.busy  = !e.ready;
        e.done  = done_nxt;
        sb.push_back(e);
    endtask

    function automatic bit m_idle();
        return (m_left == 0) && !m_wait;
    endfunction

    task automatic tick();
        model_step();
        @(negedge clk);
        wr_valid  = 1'b0;
        clear     = 1'b0;
        commit    = 1'b0;
        dir_en    = 1'b0;
        frame_cnt = frame_cnt + 1;
        vblnk_in  = ((frame_cnt % 600) >= 560);
        char_xy   = focus_en ? focus_addr : 8'($urandom);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("wr_ready", {7'd0, wr_ready}, {7'd0, e.ready});
            chk("busy", {7'd0, busy}, {7'd0, e.busy});
            chk("commit_done", {7'd0, commit_done}, {7'd0, e.done});
            if (e.rd_chk) chk("char_code", char_code, e.code);
            if (e.dir_en) chk("directed_read", char_code, e.dir_val);
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (!m_idle() && n < 3000) begin
            tick();
            n++;
        end
        if (!m_idle()) begin
            errors++;
            $display("FAIL wait_idle: timeout after %0d cycles", n);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_char  = d;
        tick();
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        wait_idle();
    endtask

    task automatic read_expect(input logic [7:0] a, input logic [7:0] v);
        focus_en   = 1'b1;
        focus_addr = a;
        char_xy    = a;
        dir_en     = 1'b1;
        dir_val    = v;
        tick();
        focus_en   = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b0; vblnk_in = 1'b0; char_xy = 8'h00; wr_valid = 1'b0;
        wr_addr = 8'h00; wr_char = 8'h00; clear = 1'b0; commit = 1'b0;
        @(negedge clk);

        // Reset and init fill
        do_reset(3);
        wait_idle();
        repeat (20) tick();

        // Write then commit while watching the written cell
        do_write(8'h23, 8'h41);
        focus_en = 1'b1; focus_addr = 8'h23; char_xy = 8'h23;
        do_commit();
        focus_en = 1'b0;
        read_expect(8'h23, 8'h41);

        // Incremental edit relies on the refresh copy
        do_write(8'h24, 8'h42);
        do_commit();
        read_expect(8'h23, 8'h41);
        read_expect(8'h24, 8'h42);

        // Clear wipes a pending write
        do_write(8'h00, 8'h55);
        clear = 1'b1;
        tick();
        wait_idle();
        do_commit();
        read_expect(8'h00, c_fill);
        read_expect(8'h23, c_fill);

        // Commit issued with vblank already high; write during the wait is dropped
        n = 0;
        while (!vblnk_in && n < 1000) begin tick(); n++; end
        commit = 1'b1;
        tick();
        repeat (5) begin
            wr_valid = 1'b1; wr_addr = 8'h10; wr_char = 8'h99;
            tick();
        end
        wait_idle();
        read_expect(8'h10, c_fill);

        // Reset in the middle of the refresh copy
        do_write(8'h30, 8'h77);
        commit = 1'b1;
        tick();
        n = 0;
        while (!(m_kind == K_COPY && m_left <= 156) && n < 2000) begin tick(); n++; end
        do_reset(2);
        wait_idle();
        read_expect(8'h30, c_fill);
        read_expect(8'h23, c_fill);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            wr_valid = ($urandom_range(0, 9) < 3);
            wr_addr  = 8'($urandom);
            wr_char  = 8'($urandom);
            clear    = ($urandom_range(0, 99) < 2);
            commit   = ($urandom_range(0, 99) < 3);
            rst      = ($urandom_range(0, 1999) == 0);
            tick();
            rst      = 1'b0;
        end
        wait_idle();
        repeat (4) tick();

        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
